// File: rtl/uart_rx_param_if.sv
// Byte stream from the UART receiver to its consumer: valid/ready handshake with head data.
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, configurable frame, error pulses, FWFT buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ser_rx,
    input  logic [DIV_WIDTH-1:0]        cfg_divider,
    uart_rx_param_if.master             m_if,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    function automatic logic parity_ok(input logic [DATA_BITS-1:0] data, input logic p);
        logic sum;
        sum = (^data) ^ p;
        if (PARITY == 1)
            return sum == 1'b1;
        else if (PARITY == 2)
            return sum == 1'b0;
        else
            return 1'b1;
    endfunction

    // Stage p0/p1: metastability guard on the asynchronous line, idles high
    logic rx_sync_p0;
    logic rx_sync_p1;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= ser_rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rx_s = rx_sync_p1;

    logic [2:0]           state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 tick;
    logic                 half;
    logic                 last_data;
    logic                 last_stop;
    logic                 push;

    assign tick      = (cnt == cfg_divider);
    assign half      = (cnt == (cfg_divider >> 1));
    assign last_data = (bit_idx == BIT_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    // A word is pushed on the last good stop sample so it is visible on the following cycle
    assign push      = (state == S_STOP) && tick && rx_s && last_stop && !par_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            cnt        <= tick ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s)
                        state <= S_START;
                end
                S_START: begin
                    if (half) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_bad  <= 1'b0;
                        state    <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (last_data)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        par_bad <= !parity_ok(shreg, rx_s);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Framing takes priority: a low stop bit hides any parity error
                    if (tick) begin
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else if (last_stop) begin
                            parity_err <= par_bad;
                            state      <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage shift: line order is LSB first, so each sample enters at the MSB
    always_ff @(posedge clk) begin
        if (state == S_DATA && tick)
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end

    logic pop;
    logic full;
    logic accept;

    assign pop    = m_if.m_valid && m_if.m_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset)
            overrun <= 1'b0;
        else
            overrun <= push && full && !pop;
    end

`ifdef UART_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    function automatic logic [LVL_W-1:0] next_level(input logic [LVL_W-1:0] lvl,
                                                    input logic inc, input logic dec);
        if (inc && !dec && lvl != LVL_W'(FIFO_DEPTH))
            return lvl + 1'b1;
        if (dec && !inc && lvl != '0)
            return lvl - 1'b1;
        return lvl;
    endfunction

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;

    assign full = (level == LVL_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= next_level(level, accept, pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= shreg;
    end

    // Storage is not reset, so the head is masked while empty to present zero
    assign m_if.m_valid = (level != '0);
    assign m_if.m_data  = m_if.m_valid ? mem[rd_ptr] : '0;
    assign fifo_level   = level;
`else
    logic [DATA_BITS-1:0] hold;
    logic                 hold_vld;

    assign full = hold_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (accept) begin
            hold     <= shreg;
            hold_vld <= 1'b1;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign m_if.m_valid = hold_vld;
    assign m_if.m_data  = hold;
    assign fifo_level   = LVL_W'(hold_vld);
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three frame formats (8N1, 8E1, 7O2) on one shared stimulus line,
// directed cases followed by randomized frames checked against a frame-level model.
module tb_uart_rx_param;
    localparam int NI = 3;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif
    localparam int DBITS [NI] = '{8, 8, 7};
    localparam int PAR   [NI] = '{0, 2, 1};
    localparam int STOPS [NI] = '{1, 1, 2};

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_line;
    int          sel;
    logic [31:0] div;
    logic        mrdy;
    logic        ser  [NI];
    logic [8:0]  mdat [NI];
    logic        mval [NI];
    logic        perr [NI];
    logic        ferr [NI];
    logic        ovr  [NI];
    logic [4:0]  lvl  [NI];

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus1 ();
    uart_rx_param_if #(.DATA_BITS(7)) bus2 ();

    uart_rx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .ser_rx(ser[0]), .cfg_divider(div), .m_if(bus0),
        .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .fifo_level(lvl[0]));
    uart_rx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .ser_rx(ser[1]), .cfg_divider(div), .m_if(bus1),
        .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .fifo_level(lvl[1]));
    uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .ser_rx(ser[2]), .cfg_divider(div), .m_if(bus2),
        .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .fifo_level(lvl[2]));

    assign ser[0] = (sel == 0) ? tx_line : 1'b1;
    assign ser[1] = (sel == 1) ? tx_line : 1'b1;
    assign ser[2] = (sel == 2) ? tx_line : 1'b1;
    assign bus0.m_ready = mrdy;
    assign bus1.m_ready = mrdy;
    assign bus2.m_ready = mrdy;
    assign mdat[0] = {1'b0, bus0.m_data};
    assign mdat[1] = {1'b0, bus1.m_data};
    assign mdat[2] = {2'b0, bus2.m_data};
    assign mval[0] = bus0.m_valid;
    assign mval[1] = bus1.m_valid;
    assign mval[2] = bus2.m_valid;

    // Observed traffic, sampled on the falling edge
    logic [10:0] got_q[$];
    int n_perr[NI], n_ferr[NI], n_ovr[NI], vcyc[NI];

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (mval[k] && mrdy) got_q.push_back({2'(k), mdat[k]});
            if (mval[k]) vcyc[k]++;
            if (perr[k]) n_perr[k]++;
            if (ferr[k]) n_ferr[k]++;
            if (ovr[k])  n_ovr[k]++;
        end
    end

    // Reference model: expected deliveries, buffered words and error pulse counts
    logic [10:0] exp_q[$];
    logic [10:0] buf_q[$];
    int e_perr[NI], e_ferr[NI], e_ovr[NI];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic good_par(input int inst, input int data);
        int ones;
        ones = $countones(data & ((1 << DBITS[inst]) - 1));
        return (PAR[inst] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic model_frame(input int inst, input int data, input logic pbit, input int stop_lo);
        if (stop_lo > 0)
            e_ferr[inst]++;
        else if (PAR[inst] != 0 && pbit != good_par(inst, data))
            e_perr[inst]++;
        else if (mrdy)
            exp_q.push_back({2'(inst), 9'(data)});
        else if (buf_q.size() < DEPTH)
            buf_q.push_back({2'(inst), 9'(data)});
        else
            e_ovr[inst]++;
    endtask

    task automatic hold(input logic v, input int n);
        tx_line = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int inst, input int data, input logic pbit,
                              input int stop_lo, input int gap);
        int bp;
        bp  = int'(div) + 1;
        sel = inst;
        hold(1'b0, bp);
        for (int i = 0; i < DBITS[inst]; i++) hold(1'((data >> i) & 1), bp);
        if (PAR[inst] != 0) hold(pbit, bp);
        for (int s = 0; s < STOPS[inst]; s++)
            if (s == 0 && stop_lo > 0) hold(1'b0, stop_lo * bp);
            else hold(1'b1, bp);
        hold(1'b1, gap * bp);
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.perr%0d", tag, k), n_perr[k], e_perr[k]);
            check($sformatf("%s.ferr%0d", tag, k), n_ferr[k], e_ferr[k]);
            check($sformatf("%s.ovr%0d", tag, k), n_ovr[k], e_ovr[k]);
        end
    endtask

    task automatic check_words(input string tag);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s.word%0d", tag, i),
                  (i < got_q.size()) ? {21'b0, got_q[i]} : 32'bx, {21'b0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.valid%0d", tag, k), mval[k], 1'b0);
            check($sformatf("%s.data%0d", tag, k), mdat[k], 9'd0);
            check($sformatf("%s.level%0d", tag, k), lvl[k], 5'd0);
            check($sformatf("%s.pulses%0d", tag, k), {perr[k], ferr[k], ovr[k]}, 3'b000);
        end
    endtask

    int         r_inst, r_data, r_kind, r_stop;
    logic       r_pb;

    initial begin
        reset = 1'b1; tx_line = 1'b1; sel = 0; div = 32'd216; mrdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;
        hold(1'b1, 4);

        // 8N1 0xA5 delivered, valid for exactly one cycle
        send_frame(0, 8'hA5, 1'b0, 0, 2);
        model_frame(0, 8'hA5, 1'b0, 0);
        check("t1.vcyc", vcyc[0], 1);
        check_words("t1");
        check_counts("t1");

        // Short low glitch is a false start
        sel = 0;
        hold(1'b0, 50);
        hold(1'b1, 400);
        check("t2.vcyc", vcyc[0], 1);
        check_words("t2");
        check_counts("t2");

        // Even parity: wrong parity bit rejected, correct one delivered
        send_frame(1, 8'h03, 1'b1, 0, 2);
        model_frame(1, 8'h03, 1'b1, 0);
        check_counts("t3a");
        check_words("t3a");
        send_frame(1, 8'h03, 1'b0, 0, 2);
        model_frame(1, 8'h03, 1'b0, 0);
        check_counts("t3b");
        check_words("t3b");

        // Low stop bit then line held low: single frame error, then recovery
        send_frame(0, 8'h81, 1'b0, 6, 2);
        model_frame(0, 8'h81, 1'b0, 6);
        check_counts("t4a");
        check_words("t4a");
        send_frame(0, 8'h5A, 1'b0, 0, 2);
        model_frame(0, 8'h5A, 1'b0, 0);
        check_counts("t4b");
        check_words("t4b");

        // Fill the buffer with consumer stalled, one extra word overruns
        div = 32'd15;
        mrdy = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(0, i, 1'b0, 0, 1);
            model_frame(0, i, 1'b0, 0);
            check_counts($sformatf("t5.fill%0d", i));
        end
        check("t5.level", lvl[0], 5'(DEPTH));
        check("t5.head", mdat[0], 9'd0);
        mrdy = 1'b1;
        hold(1'b1, DEPTH + 4);
        while (buf_q.size() > 0) exp_q.push_back(buf_q.pop_front());
        check_words("t5.drain");
        check("t5.empty", lvl[0], 5'd0);

        // Reset in the middle of a frame with a word held
        div = 32'd40;
        mrdy = 1'b0;
        send_frame(0, 8'h11, 1'b0, 0, 1);
        model_frame(0, 8'h11, 1'b0, 0);
        check("t6.held", lvl[0], 5'd1);
        sel = 0;
        hold(1'b0, 41);
        for (int i = 0; i < 3; i++) hold(1'b1, 41);
        reset = 1'b1;
        tx_line = 1'b1;
        hold(1'b1, 1);
        check_quiet("t6.reset");
        hold(1'b1, 2);
        reset = 1'b0;
        buf_q.delete();
        hold(1'b1, 100);
        mrdy = 1'b1;
        send_frame(0, 8'h3C, 1'b0, 0, 2);
        model_frame(0, 8'h3C, 1'b0, 0);
        check_words("t6");
        check_counts("t6");

        // Randomized frames across all formats, dividers and error kinds
        for (int f = 0; f < 30; f++) begin
            r_inst = $urandom_range(0, 2);
            r_data = $urandom_range(0, (1 << DBITS[r_inst]) - 1);
            r_kind = $urandom_range(0, 3);
            r_pb   = good_par(r_inst, r_data);
            if (r_kind[0]) r_pb = ~r_pb;
            r_stop = (r_kind >= 2) ? 1 : 0;
            div    = 32'($urandom_range(6, 30));
            send_frame(r_inst, r_data, r_pb, r_stop, 2);
            model_frame(r_inst, r_data, r_pb, r_stop);
            check_counts($sformatf("rnd%0d", f));
            check_words($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
